timer_irq: RTL and testbench
============================

# timer_irq

Programmable down-counting timer that drives the CPU's `interrupt` input. It is the device-side source of the interrupt line the `mips` core samples. It is mapped behind the system bridge as a three-register peripheral. The CPU writes a preset value and control word, the timer counts down once per clock, and it raises `irq` on expiry, either as a one-shot or as an auto-reloading periodic source.

## Interface
Parameters:
- `WIDTH`, default 32: width of the count/preset registers and of the data bus.

Ports:
- `clk`  in  1: system clock, rising-edge.
- `reset`  in  1: asynchronous, active-low reset (0 = reset).
- `addr`  in  2: word select (bridge address bits [3:2]): 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unused.
- `we`  in  1: write strobe, sampled on the rising edge of `clk`.
- `wdata`  in  WIDTH: write data.
- `rdata`  out  WIDTH: combinational read data for `addr`.
- `irq`  out  1: interrupt request to CPU, `irq = ctrl.IM & irq_flag`.

## Operation
- CTRL register:
  - bit0 = EN (enable); bits[2:1] = MODE (0 one-shot, 1 auto-reload; 2/3 behave as 0); bit3 = IM (interrupt mask, 1 = pass).
  - Bits [WIDTH-1:4] are read as 0 and ignored on write.
- PRESET: read/write, full WIDTH.
- COUNT: read-only. Writes to addr 2 or 3 are ignored; a read of addr 3 returns 0.
- Any write to CTRL or PRESET clears `irq_flag`.
- FSM states are IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, go to LOAD.
  - LOAD: `count <= preset`, go to CNT; if EN=0, go to IDLE instead.
  - CNT:
    - If EN=0, go to IDLE and `count` holds its value.
    - Else if `count==0`, go to INT.
    - Else `count <= count-1`; if `count==1`, also go to INT.
  - INT:
    - MODE 1: go to LOAD and clear `irq_flag`, giving a one-cycle pulse.
    - Otherwise: clear EN, go to IDLE. `irq_flag` stays set until a CTRL/PRESET write.
- `irq_flag` is set on the edge that enters INT.
- Writing PRESET during CNT does not alter the running `count`; the new value is used at the next LOAD.
- Arithmetic is unsigned. `count` never wraps below 0.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, `irq_flag`=0, `irq`=0.
  - Assertion takes effect immediately, without waiting for a clock edge; `irq` drops within the same cycle.
  - Reset mid-count discards all state.
- Register writes update on the edge where `we=1`. `rdata` reflects the new value in the following cycle.
- EN written to 1 on edge E:
  - LOAD at edge E+1.
  - COUNT=PRESET=N at edge E+2.
  - INT entered and `irq_flag` set at edge E+2+max(N,1).
- Auto-reload period: N+2 cycles between `irq` rising edges. `irq` is high for exactly 1 cycle per period.
- Simultaneous events:
  - A CPU write to CTRL on the same edge that INT clears EN: the CPU write wins, and CTRL takes `wdata[3:0]`.
  - A CPU write to CTRL/PRESET on the same edge that `irq_flag` would be set: the set wins, so the flag becomes 1.
- EN cleared by a CPU write: the FSM sees it one edge later and enters IDLE. No interrupt is raised if expiry was not already reached.
- IM=0 masks `irq` only; `irq_flag` still updates and becomes visible if IM is later set.

## Test plan
- Reset: hold `reset`=0 with writes active, then release. Read CTRL/PRESET/COUNT -> all 0; `irq`=0 throughout.
- One-shot: PRESET=5, then CTRL=0x9 (EN, MODE0, IM) at edge E.
  - `irq` rises after edge E+7 and stays high; COUNT=0; CTRL reads 0x8.
  - A PRESET write then drops `irq` on the next edge.
- Auto-reload: PRESET=3, CTRL=0xB.
  - `irq` pulses 1 cycle every 5 cycles for at least 4 periods.
  - COUNT cycles 3,2,1,0 between pulses.
- Masking and stop:
  - PRESET=4, CTRL=0x1 (IM=0): `irq` stays 0 after expiry; writing CTRL=0x8 does not raise `irq`, because the write clears the flag.
  - Separately, writing CTRL=0 mid-count freezes COUNT at its current value, and no `irq` occurs.
- Edge values:
  - PRESET=0 with EN: `irq` at E+3.
  - PRESET=0xFFFFFFFF: COUNT decrements without wrap.
  - PRESET rewritten to 2 mid-count in MODE1: the current period completes with the old value, and the next period is 4 cycles.
- Async reset mid-count: assert `reset`=0 between clock edges while COUNT=7. COUNT and `irq` go to 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/timer_irq.sv
// timer_irq: programmable down-counting timer with a three-word register map
// (CTRL, PRESET, COUNT) and an interrupt output. It runs as a one-shot or as an
// auto-reloading periodic source.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | stopped; waiting for CTRL.EN
// LOAD  | copy PRESET into COUNT on the next edge
// CNT   | decrement COUNT once per clock until it reaches zero
// INT   | expiry; reload (MODE 1) or clear EN and stop (other modes)
module timer_irq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0]       ADDR_CTRL   = 2'd0;
  localparam logic [1:0]       ADDR_PRESET = 2'd1;
  localparam logic [1:0]       ADDR_COUNT  = 2'd2;
  localparam logic [WIDTH-1:0] CNT_ONE     = WIDTH'(1);

  // ctrl_q: [0]=EN, [2:1]=MODE, [3]=IM
  logic [3:0]       ctrl_q,     ctrl_d;
  logic [WIDTH-1:0] preset_q,   preset_d;
  logic [WIDTH-1:0] count_q,    count_d;
  state_t           state_q,    state_d;
  logic             irq_flag_q, irq_flag_d;

  logic en;
  logic auto_reload;
  logic set_flag;
  logic clr_flag_reload;

  assign en          = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);

  // Next-state, counter and register-write logic. The CPU write to CTRL is
  // applied after the FSM so it overrides the EN clear at expiry; the expiry
  // set of irq_flag is applied last so it overrides any write-side clear.
  always_comb begin
    ctrl_d          = ctrl_q;
    preset_d        = preset_q;
    count_d         = count_q;
    state_d         = state_q;
    irq_flag_d      = irq_flag_q;
    set_flag        = 1'b0;
    clr_flag_reload = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!en) begin
          state_d = S_IDLE;
        end else begin
          count_d = preset_q;
          state_d = S_CNT;
        end
      end
      S_CNT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (count_q == '0) begin
          state_d  = S_INT;
          set_flag = 1'b1;
        end else begin
          count_d = count_q - CNT_ONE;
          if (count_q == CNT_ONE) begin
            state_d  = S_INT;
            set_flag = 1'b1;
          end
        end
      end
      S_INT: begin
        if (auto_reload) begin
          state_d         = S_LOAD;
          clr_flag_reload = 1'b1;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (we) begin
      case (addr)
        ADDR_CTRL: begin
          ctrl_d     = wdata[3:0];
          irq_flag_d = 1'b0;
        end
        ADDR_PRESET: begin
          preset_d   = wdata;
          irq_flag_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (clr_flag_reload) irq_flag_d = 1'b0;
    if (set_flag)        irq_flag_d = 1'b1;
  end

  // State and register flops; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      irq_flag_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      state_q    <= state_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Combinational read mux; unused CTRL bits and address 3 read as zero.
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_CTRL:   rdata = WIDTH'(ctrl_q);
      ADDR_PRESET: rdata = preset_q;
      ADDR_COUNT:  rdata = count_q;
      default:     rdata = '0;
    endcase
  end

  assign irq = ctrl_q[3] & irq_flag_q;

endmodule

// File: tb/tb_timer_irq.sv
module tb_timer_irq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int pass_cnt = 0;
  int total_cnt = 0;

  timer_irq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One-cycle register write; returns 1ns after the capturing edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    #2 reset = 1'b0;
    we = 1'b1;
    addr = 2'd0;
    wdata = 32'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (irq !== 1'b0) $display("FAIL reset_irq_held: got %b expected 0", irq);
      else pass_cnt++;
    end
    addr = 2'd1;
    wdata = 32'h5;
    tick();
    we = 1'b0;
    #1 reset = 1'b1;
    tick();
    rd(2'd0, v);
    total_cnt++;
    if (v !== 32'd0) $display("FAIL reset_ctrl: got %h expected 0", v);
    else pass_cnt++;
    rd(2'd1, v);
    total_cnt++;
    if (v !== 32'd0) $display("FAIL reset_preset: got %h expected 0", v);
    else pass_cnt++;
    rd(2'd2, v);
    total_cnt++;
    if (v !== 32'd0) $display("FAIL reset_count: got %h expected 0", v);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL reset_irq_after: got %b expected 0", irq);
    else pass_cnt++;
  endtask

  task automatic test_oneshot;
    logic [31:0] v;
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      tick();
      total_cnt++;
      if (irq !== 1'b0) $display("FAIL oneshot_early k=%0d: got %b expected 0", k, irq);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL oneshot_fire: got %b expected 1", irq);
    else pass_cnt++;
    rd(2'd2, v);
    total_cnt++;
    if (v !== 32'd0) $display("FAIL oneshot_count: got %h expected 0", v);
    else pass_cnt++;
    tick();
    tick();
    rd(2'd0, v);
    total_cnt++;
    if (v !== 32'h8) $display("FAIL oneshot_ctrl: got %h expected 8", v);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL oneshot_hold: got %b expected 1", irq);
    else pass_cnt++;
    wr(2'd1, 32'd7);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL oneshot_clear: got %b expected 0", irq);
    else pass_cnt++;
  endtask

  task automatic test_autoreload;
    logic [31:0] v;
    logic [31:0] exp_cnt;
    logic        exp_irq;
    int          p;
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 25; k++) begin
      tick();
      rd(2'd2, v);
      if (k == 1) begin
        exp_cnt = 32'd0;
      end else begin
        p = (k - 2) % 5;
        exp_cnt = (p <= 3) ? 32'(3 - p) : 32'd0;
      end
      exp_irq = (k >= 5) && (((k - 5) % 5) == 0);
      total_cnt++;
      if (irq !== exp_irq) $display("FAIL reload_irq k=%0d: got %b expected %b", k, irq, exp_irq);
      else pass_cnt++;
      total_cnt++;
      if (v !== exp_cnt) $display("FAIL reload_count k=%0d: got %h expected %h", k, v, exp_cnt);
      else pass_cnt++;
    end
    wr(2'd0, 32'h0);
  endtask

  task automatic test_mask;
    logic [31:0] v;
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      total_cnt++;
      if (irq !== 1'b0) $display("FAIL mask_irq k=%0d: got %b expected 0", k, irq);
      else pass_cnt++;
    end
    wr(2'd0, 32'h8);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL mask_unmask: got %b expected 0", irq);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL mask_unmask_late: got %b expected 0", irq);
    else pass_cnt++;
    rd(2'd0, v);
    total_cnt++;
    if (v !== 32'h8) $display("FAIL mask_ctrl: got %h expected 8", v);
    else pass_cnt++;
    wr(2'd0, 32'h0);
  endtask

  task automatic test_simultaneous;
    logic [31:0] v;
    // Unmasking write lands on the expiry edge: set beats the write clear.
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 5; k++) tick();
    wr(2'd0, 32'h8);
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL set_wins: got %b expected 1", irq);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL set_wins_hold: got %b expected 1", irq);
    else pass_cnt++;
    wr(2'd1, 32'd2);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL set_wins_clear: got %b expected 0", irq);
    else pass_cnt++;
    // CTRL write on the INT->IDLE edge keeps EN set and restarts the timer.
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      tick();
      total_cnt++;
      if (irq !== 1'b0) $display("FAIL cpu_wins_pre k=%0d: got %b expected 0", k, irq);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL cpu_wins_fire1: got %b expected 1", irq);
    else pass_cnt++;
    wr(2'd0, 32'h9);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL cpu_wins_clear: got %b expected 0", irq);
    else pass_cnt++;
    rd(2'd0, v);
    total_cnt++;
    if (v !== 32'h9) $display("FAIL cpu_wins_ctrl: got %h expected 9", v);
    else pass_cnt++;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total_cnt++;
      if (irq !== 1'b0) $display("FAIL cpu_wins_run k=%0d: got %b expected 0", k, irq);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL cpu_wins_fire2: got %b expected 1", irq);
    else pass_cnt++;
    wr(2'd0, 32'h0);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL cpu_wins_stop: got %b expected 0", irq);
    else pass_cnt++;
  endtask

  task automatic test_stop;
    logic [31:0] v;
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) tick();
    wr(2'd0, 32'h0);
    rd(2'd2, v);
    total_cnt++;
    if (v !== 32'd7) $display("FAIL stop_count_now: got %h expected 7", v);
    else pass_cnt++;
    for (int k = 1; k <= 12; k++) begin
      tick();
      total_cnt++;
      if (irq !== 1'b0) $display("FAIL stop_irq k=%0d: got %b expected 0", k, irq);
      else pass_cnt++;
    end
    rd(2'd2, v);
    total_cnt++;
    if (v !== 32'd7) $display("FAIL stop_count_frozen: got %h expected 7", v);
    else pass_cnt++;
  endtask

  task automatic test_edges;
    logic [31:0] v;
    logic        exp_irq;
    // PRESET = 0 expires on E+3.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 2; k++) begin
      tick();
      total_cnt++;
      if (irq !== 1'b0) $display("FAIL zero_early k=%0d: got %b expected 0", k, irq);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL zero_fire: got %b expected 1", irq);
    else pass_cnt++;
    rd(2'd2, v);
    total_cnt++;
    if (v !== 32'd0) $display("FAIL zero_count: got %h expected 0", v);
    else pass_cnt++;
    wr(2'd0, 32'h0);
    // Full-scale preset decrements without wrap.
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd0, 32'h9);
    tick();
    tick();
    rd(2'd2, v);
    total_cnt++;
    if (v !== 32'hFFFF_FFFF) $display("FAIL max_load: got %h expected ffffffff", v);
    else pass_cnt++;
    tick();
    rd(2'd2, v);
    total_cnt++;
    if (v !== 32'hFFFF_FFFE) $display("FAIL max_dec1: got %h expected fffffffe", v);
    else pass_cnt++;
    tick();
    rd(2'd2, v);
    total_cnt++;
    if (v !== 32'hFFFF_FFFD) $display("FAIL max_dec2: got %h expected fffffffd", v);
    else pass_cnt++;
    wr(2'd0, 32'h0);
    tick();
    rd(2'd2, v);
    total_cnt++;
    if (v !== 32'hFFFF_FFFC) $display("FAIL max_stop: got %h expected fffffffc", v);
    else pass_cnt++;
    // PRESET rewritten mid-count only affects the following period.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 3; k++) tick();
    wr(2'd1, 32'd2);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL rewrite_early: got %b expected 0", irq);
    else pass_cnt++;
    for (int k = 5; k <= 16; k++) begin
      tick();
      exp_irq = (k == 7) || (k == 11) || (k == 15);
      total_cnt++;
      if (irq !== exp_irq) $display("FAIL rewrite_irq k=%0d: got %b expected %b", k, irq, exp_irq);
      else pass_cnt++;
      if (k == 9) begin
        rd(2'd2, v);
        total_cnt++;
        if (v !== 32'd2) $display("FAIL rewrite_count: got %h expected 2", v);
        else pass_cnt++;
      end
    end
    wr(2'd0, 32'h0);
  endtask

  task automatic test_async_reset;
    logic [31:0] v;
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 15; k++) tick();
    rd(2'd2, v);
    total_cnt++;
    if (v !== 32'd7) $display("FAIL areset_pre_count: got %h expected 7", v);
    else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    rd(2'd2, v);
    total_cnt++;
    if (v !== 32'd0) $display("FAIL areset_count: got %h expected 0", v);
    else pass_cnt++;
    rd(2'd0, v);
    total_cnt++;
    if (v !== 32'd0) $display("FAIL areset_ctrl: got %h expected 0", v);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL areset_irq: got %b expected 0", irq);
    else pass_cnt++;
    #1 reset = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    rd(2'd2, v);
    total_cnt++;
    if (v !== 32'd0) $display("FAIL areset_after: got %h expected 0", v);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_mask();
    test_simultaneous();
    test_stop();
    test_edges();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
